// File: rtl/pl_trace_pkg.sv
// pl_trace_pkg: shared record kinds, header layout, serializer states and record metadata
package pl_trace_pkg;
  localparam logic [1:0] KIND_REG = 2'b01;
  localparam logic [1:0] KIND_MEM = 2'b10;
  localparam int KIND_MSB = 31;
  localparam int KIND_LSB = 30;
  localparam int RD_MSB = 29;
  localparam int RD_LSB = 25;
  localparam int SEQ_MSB = 15;
  localparam int SEQ_LSB = 0;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_W1, S_W2} state_t;
  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [15:0] seq;
  } trace_rec_t;
  function automatic logic [31:0] hdr_word(trace_rec_t r);
    logic [31:0] h;
    h = '0;
    h[KIND_MSB:KIND_LSB] = r.kind;
    h[RD_MSB:RD_LSB] = r.rd;
    h[SEQ_MSB:SEQ_LSB] = r.seq;
    return h;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: 2-write/1-read record FIFO; port 0 has priority for the last free slot
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int FW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0,
  input  logic [W-1:0]  din0,
  input  logic          push1,
  input  logic [W-1:0]  din1,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [FW-1:0] fill,
  output logic          drop
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, wp1;
  logic [FW-1:0] fill_q, fill_d, free;
  logic acc0, acc1;
  // a pop on the same edge frees a slot for the incoming push
  always_comb begin
    free = FW'(DEPTH) - fill_q + FW'(pop);
    acc0 = push0 && free != '0;
    acc1 = push1 && free > FW'(acc0);
    drop = (push0 && !acc0) || (push1 && !acc1);
    wp1 = wp_q + AW'(acc0);
    wp_d = wp1 + AW'(acc1);
    rp_d = rp_q + AW'(pop);
    fill_d = fill_q + FW'(acc0) + FW'(acc1) - FW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      fill_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      fill_q <= fill_d;
      if (acc0) mem_q[wp_q] <= din0;
      if (acc1) mem_q[wp1] <= din1;
    end
  end
  assign dout = mem_q[rp_q];
  assign fill = fill_q;
endmodule

// File: rtl/wb_trace_capture.sv
// wb_trace_capture: records write-back commits and streams them as 3-word packets.
// Define TRACE_MEM_EN to also capture data-memory stores as MEM records.
module wb_trace_capture
  import pl_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [DATA_W-1:0]        wb_pc,
  input  logic [4:0]               wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [DATA_W-1:0]        trace_word,
  output logic                     trace_last,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int MW = $bits(trace_rec_t);
  localparam int RW = MW + 2 * DATA_W;
  state_t state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic valid_q, valid_d, last_q, last_d, overflow_q, overflow_d;
  logic [DATA_W-1:0] word_q, word_d, a_q, a_d, d_q, d_d;
  logic reg_gen, mem_gen, fire, load, drop;
  logic [RW-1:0] rec0, rec1, head;
  trace_rec_t head_rec;
`ifdef TRACE_MEM_EN
  assign mem_gen = mem_we;
`else
  logic unused_mem;
  assign mem_gen = 1'b0;
  assign unused_mem = ^{mem_we, mem_addr, mem_wdata};
`endif
  assign reg_gen = wb_valid && wb_rd != 5'd0;
  assign rec0 = {KIND_REG, wb_rd, seq_q, wb_pc, wb_data};
  assign rec1 = {KIND_MEM, 5'd0, seq_q + 16'(reg_gen), mem_addr, mem_wdata};
  assign head_rec = head[RW-1:2*DATA_W];
  assign fire = valid_q && trace_ready;
  assign load = fill != '0 && (state_q == S_IDLE || (state_q == S_W2 && fire));
  trace_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk(clk), .reset(reset),
    .push0(reg_gen), .din0(rec0),
    .push1(mem_gen), .din1(rec1),
    .pop(load), .dout(head), .fill(fill), .drop(drop)
  );
  // a dropped record still consumes its seq so the gap is visible downstream
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    word_d = word_q;
    last_d = last_q;
    a_d = a_q;
    d_d = d_q;
    seq_d = seq_q + 16'(reg_gen) + 16'(mem_gen);
    overflow_d = overflow_q | drop;
    if (load) begin
      state_d = S_HDR;
      valid_d = 1'b1;
      word_d = DATA_W'(hdr_word(head_rec));
      last_d = 1'b0;
      a_d = head[2*DATA_W-1:DATA_W];
      d_d = head[DATA_W-1:0];
    end else if (fire) begin
      case (state_q)
        S_HDR: begin
          state_d = S_W1;
          word_d = a_q;
        end
        S_W1: begin
          state_d = S_W2;
          word_d = d_q;
          last_d = 1'b1;
        end
        S_W2: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          word_d = '0;
          last_d = 1'b0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      seq_q <= '0;
      valid_q <= 1'b0;
      word_q <= '0;
      last_q <= 1'b0;
      overflow_q <= 1'b0;
      a_q <= '0;
      d_q <= '0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      valid_q <= valid_d;
      word_q <= word_d;
      last_q <= last_d;
      overflow_q <= overflow_d;
      a_q <= a_d;
      d_q <= d_d;
    end
  end
  assign trace_valid = valid_q;
  assign trace_word = word_q;
  assign trace_last = last_q;
  assign overflow = overflow_q;
endmodule
